// File: rtl/nn_pkg.sv
// Shared types and constants for the weight-update datapath: FSM states,
// the signed Q3.7 weight word and its saturation bounds.
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    CALC,
    WRITE,
    DONE
  } state_t;

  typedef logic signed [9:0] weight_t;

  localparam int WORD_W      = 10;
  localparam int PROD_W      = 20;
  localparam int ADDR_W      = 7;
  localparam int Q_INT_BITS  = 3;
  localparam int Q_FRAC_BITS = 7;

  localparam weight_t WEIGHT_MIN = -10'sd512;
  localparam weight_t WEIGHT_MAX = 10'sd511;

endpackage

// File: rtl/weight_adjust.sv
// Combinational weight update: new = sat(w + (delta*outcal >>> (FRAC_BITS+LR_SHIFT))),
// with a flag raised whenever the saturation actually clipped the sum.
module weight_adjust
  import nn_pkg::*;
#(
  parameter int FRAC_BITS = 7,
  parameter int LR_SHIFT  = 3
) (
  input  logic signed [9:0] delta_i,
  input  logic [9:0]        outcal_i,
  input  logic signed [9:0] w_i,
  output logic signed [9:0] new_o,
  output logic              clip_o
);

  localparam logic signed [19:0] SUM_HI = 20'(WEIGHT_MAX);
  localparam logic signed [19:0] SUM_LO = 20'(WEIGHT_MIN);

  logic signed [19:0] d_ext;
  logic signed [19:0] o_ext;
  logic signed [19:0] prod;
  logic signed [19:0] adj;
  logic signed [19:0] sum;

  function automatic weight_t sat_weight(input logic signed [19:0] v);
    if (v > SUM_HI)      return WEIGHT_MAX;
    else if (v < SUM_LO) return WEIGHT_MIN;
    else                 return v[9:0];
  endfunction

  // OutCal is unsigned, so it is zero-extended before the signed multiply
  assign d_ext  = 20'(delta_i);
  assign o_ext  = {10'd0, outcal_i};
  assign prod   = d_ext * o_ext;
  assign adj    = prod >>> (FRAC_BITS + LR_SHIFT);
  assign sum    = 20'(w_i) + adj;
  assign new_o  = sat_weight(sum);
  assign clip_o = (sum > SUM_HI) || (sum < SUM_LO);

endmodule

// File: rtl/weight_update_sequencer.sv
// Walks every output-layer weight in neuron-major order, read-modify-writing
// the weight RAM with a 2^-LR_SHIFT scaled delta*activation step.
// Optional saturation counter output enabled by defining WUS_SAT_COUNT_EN.
module weight_update_sequencer
  import nn_pkg::*;
#(
  parameter int N_OUT     = 3,
  parameter int N_HID     = 5,
  parameter int BASE_ADDR = 50,
  parameter int FRAC_BITS = 7,
  parameter int LR_SHIFT  = 3
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [10*N_OUT-1:0]   Delta,
  input  logic [10*N_HID-1:0]   OutCal,
  output logic [6:0]            RamAddr,
  output logic                  RamWE,
  output logic [9:0]            RamWData,
  input  logic [9:0]            RamRData,
  output logic                  Busy,
  output logic                  Done
`ifdef WUS_SAT_COUNT_EN
  ,
  output logic [7:0]            SatCount
`endif
);

  localparam int NW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int HW = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam logic [NW-1:0] N_LAST = NW'(N_OUT - 1);
  localparam logic [HW-1:0] H_LAST = HW'(N_HID - 1);
  localparam logic [6:0]    ADDR0  = 7'(BASE_ADDR);

  state_t        state_q;
  logic [NW-1:0] n_q, n_d;
  logic [HW-1:0] h_q, h_d;
  logic [6:0]    addr_d;
  weight_t       w_q;
  weight_t       delta_q  [N_OUT];
  logic [9:0]    outcal_q [N_HID];
  weight_t       new_w;
  logic          clip;
  logic          last;

  always_comb begin
    h_d = h_q + 1'b1;
    n_d = n_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      n_d = n_q + 1'b1;
    end
    addr_d = 7'(BASE_ADDR + int'(n_d) * N_HID + int'(h_d));
  end

  assign last = (h_q == H_LAST) && (n_q == N_LAST);

  weight_adjust #(
    .FRAC_BITS (FRAC_BITS),
    .LR_SHIFT  (LR_SHIFT)
  ) u_adjust (
    .delta_i  (delta_q[n_q]),
    .outcal_i (outcal_q[h_q]),
    .w_i      (w_q),
    .new_o    (new_w),
    .clip_o   (clip)
  );

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      h_q      <= '0;
      w_q      <= '0;
      RamAddr  <= '0;
      RamWE    <= 1'b0;
      RamWData <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      for (int i = 0; i < N_OUT; i++) delta_q[i] <= '0;
      for (int j = 0; j < N_HID; j++) outcal_q[j] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            for (int i = 0; i < N_OUT; i++) delta_q[i] <= Delta[10*i +: 10];
            for (int j = 0; j < N_HID; j++) outcal_q[j] <= OutCal[10*j +: 10];
            n_q     <= '0;
            h_q     <= '0;
            RamAddr <= ADDR0;
            Busy    <= 1'b1;
            state_q <= READ;
          end
        end
        READ: state_q <= WAIT;
        // RAM data for the address presented in READ is valid here
        WAIT: begin
          w_q     <= RamRData;
          state_q <= CALC;
        end
        CALC: begin
          RamWData <= new_w;
          RamWE    <= 1'b1;
          state_q  <= WRITE;
        end
        WRITE: begin
          RamWE <= 1'b0;
          if (last) begin
            n_q     <= '0;
            h_q     <= '0;
            Done    <= 1'b1;
            state_q <= DONE;
          end else begin
            n_q     <= n_d;
            h_q     <= h_d;
            RamAddr <= addr_d;
            state_q <= READ;
          end
        end
        DONE: begin
          Done    <= 1'b0;
          Busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef WUS_SAT_COUNT_EN
  logic [7:0] sat_cnt_q;

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      sat_cnt_q <= '0;
    end else if (state_q == IDLE && Start) begin
      sat_cnt_q <= '0;
    end else if (state_q == CALC && clip && sat_cnt_q != 8'hFF) begin
      sat_cnt_q <= sat_cnt_q + 1'b1;
    end
  end

  assign SatCount = sat_cnt_q;
`endif

endmodule

// File: tb/tb_weight_update_sequencer.sv
// Scoreboard bench for weight_update_sequencer: expected RAM writes are queued
// as each pass is launched and a forked monitor checks every RamWE cycle.
`timescale 1ns/1ps
module tb_weight_update_sequencer;

  localparam int N_OUT = 3;
  localparam int N_HID = 5;
  localparam int BASE  = 50;

  logic        Clock = 1'b0;
  logic        Rst;
  logic        Start;
  logic [29:0] Delta;
  logic [49:0] OutCal;
  logic [6:0]  RamAddr;
  logic        RamWE;
  logic [9:0]  RamWData;
  logic [9:0]  RamRData;
  logic        Busy;
  logic        Done;
`ifdef WUS_SAT_COUNT_EN
  logic [7:0]  SatCount;
`endif

  always #5 Clock = ~Clock;

  weight_update_sequencer dut (
    .Clock    (Clock),
    .Rst      (Rst),
    .Start    (Start),
    .Delta    (Delta),
    .OutCal   (OutCal),
    .RamAddr  (RamAddr),
    .RamWE    (RamWE),
    .RamWData (RamWData),
    .RamRData (RamRData),
    .Busy     (Busy),
    .Done     (Done)
`ifdef WUS_SAT_COUNT_EN
    ,
    .SatCount (SatCount)
`endif
  );

  logic [9:0] mem [128];
  logic       pre_we;
  logic [6:0] pre_a;
  logic [9:0] pre_d;
  int         cyc = 0;

  always @(posedge Clock) begin
    cyc      <= cyc + 1;
    RamRData <= mem[RamAddr];
    if (RamWE)       mem[RamAddr] <= RamWData;
    else if (pre_we) mem[pre_a]   <= pre_d;
  end

  typedef struct {
    int a;
    int d;
  } wr_t;

  wr_t exp_q[$];
  int  exp_mem [128];
  int  dl [N_OUT];
  int  oc [N_HID];
  int  vectors    = 0;
  int  miscompares = 0;
  int  done_seen  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge Clock);
      if (Done) done_seen++;
      if (RamWE) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: addr %0d data %0d, no write expected",
                   RamAddr, $signed(RamWData));
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(RamAddr), e.a);
          chk("wr_data", int'($signed(RamWData)), e.d);
        end
      end
    end
  endtask

  function automatic int model_w(input int w, input int d, input int o);
    int s;
    s = w + ((d * o) >>> 10);
    if (s > 511)  s = 511;
    if (s < -512) s = -512;
    return s;
  endfunction

  task automatic push_pass(input int limit);
    int  k;
    int  a;
    wr_t e;
    k = 0;
    for (int n = 0; n < N_OUT; n++) begin
      for (int h = 0; h < N_HID; h++) begin
        if (k < limit) begin
          a = BASE + n * N_HID + h;
          exp_mem[a] = model_w(exp_mem[a], dl[n], oc[h]);
          e.a = a;
          e.d = exp_mem[a];
          exp_q.push_back(e);
        end
        k++;
      end
    end
  endtask

  task automatic set_ops();
    for (int n = 0; n < N_OUT; n++) Delta[10*n +: 10] = 10'(dl[n]);
    for (int h = 0; h < N_HID; h++) OutCal[10*h +: 10] = 10'(oc[h]);
  endtask

  task automatic preload(input int a, input int v);
    pre_we = 1'b1;
    pre_a  = 7'(a);
    pre_d  = 10'(v);
    exp_mem[a] = v;
    @(negedge Clock);
    pre_we = 1'b0;
  endtask

  task automatic start_pulse(output int se);
    Start = 1'b1;
    se    = cyc + 1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (Done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: Done never seen, got timeout, expected pulse", nm);
    end
  endtask

  int se, at, a1, a2, d0, m57, m58;
  logic found;

  initial begin
    Rst = 1'b1; Start = 1'b1; Delta = '0; OutCal = '0;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    for (int i = 0; i < 128; i++) exp_mem[i] = 0;
    fork
      monitor();
    join_none

    // reset state, with Start held high during reset
    repeat (3) @(negedge Clock);
    chk("rst_busy",  int'(Busy), 0);
    chk("rst_done",  int'(Done), 0);
    chk("rst_we",    int'(RamWE), 0);
    chk("rst_addr",  int'(RamAddr), 0);
    chk("rst_wdata", int'(RamWData), 0);
    Start = 1'b0;
    Rst   = 1'b0;
    @(negedge Clock);
    chk("idle_busy", int'(Busy), 0);

    for (int a = BASE; a < BASE + 15; a++) preload(a, (a == BASE) ? 100 : (a - BASE) * 7 - 40);

    // basic update of weight (0,0)
    dl = '{64, 0, 0};
    oc = '{128, 0, 0, 0, 0};
    set_ops();
    push_pass(15);
    start_pulse(se);
    wait_done("A_done", at);
    chk("A_latency", at - se, 60);
    @(negedge Clock);
    chk("A_done_width", int'(Done), 0);
    chk("A_idle_busy", int'(Busy), 0);
    chk("A_queue", exp_q.size(), 0);
    chk("A_ram50", int'($signed(mem[50])), 108);
    chk("A_ram51", int'($signed(mem[51])), -33);
    chk("A_ram64", int'($signed(mem[64])), 58);

    // positive saturation at address 55
    preload(55, 500);
    dl = '{0, 511, 0};
    oc = '{1023, 0, 0, 0, 0};
    set_ops();
    push_pass(15);
    start_pulse(se);
    wait_done("B_done", at);
    @(negedge Clock);
    chk("B_ram55", int'($signed(mem[55])), 511);
    chk("B_ram50", int'($signed(mem[50])), 108);
`ifdef WUS_SAT_COUNT_EN
    chk("B_satcount", int'(SatCount), 1);
`endif

    // negative saturation at address 60
    preload(60, -500);
    dl = '{0, 0, -512};
    set_ops();
    push_pass(15);
    start_pulse(se);
    wait_done("C_done", at);
    @(negedge Clock);
    chk("C_ram60", int'($signed(mem[60])), -512);
`ifdef WUS_SAT_COUNT_EN
    chk("C_satcount", int'(SatCount), 1);
`endif

    // Start re-pulsed at edge 20 of a pass must be ignored
    dl = '{100, -200, 300};
    oc = '{10, 20, 30, 40, 50};
    set_ops();
    push_pass(15);
    d0 = done_seen;
    start_pulse(se);
    while (cyc < se + 19) @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_done("D_done", at);
    chk("D_latency", at - se, 60);
    repeat (10) @(negedge Clock);
    chk("D_done_count", done_seen - d0, 1);
    chk("D_queue", exp_q.size(), 0);
    chk("D_busy", int'(Busy), 0);

    // reset mid-WRITE of address 57 aborts the pass
    dl = '{50, 60, 70};
    oc = '{200, 300, 400, 500, 600};
    set_ops();
    push_pass(7);
    m57 = int'($signed(mem[57]));
    m58 = int'($signed(mem[58]));
    start_pulse(se);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge Clock);
      #1;
      if (RamWE && RamAddr == 7'd57) begin
        found = 1'b1;
        break;
      end
    end
    chk("E_found_write57", int'(found), 1);
    Rst = 1'b1;
    #1;
    chk("E_we_drop", int'(RamWE), 0);
    chk("E_busy_drop", int'(Busy), 0);
    chk("E_addr_clr", int'(RamAddr), 0);
    repeat (3) @(negedge Clock);
    Rst = 1'b0;
    repeat (8) @(negedge Clock);
    chk("E_ram57", int'($signed(mem[57])), m57);
    chk("E_ram58", int'($signed(mem[58])), m58);
    chk("E_queue", exp_q.size(), 0);
    chk("E_busy", int'(Busy), 0);

    // Start held high: back-to-back passes 62 cycles apart
    dl = '{-100, 80, -60};
    oc = '{500, 400, 300, 200, 100};
    set_ops();
    push_pass(15);
    push_pass(15);
    Start = 1'b1;
    se = cyc + 1;
    wait_done("F_done1", a1);
    chk("F_latency", a1 - se, 60);
    @(negedge Clock);
    chk("F_done1_width", int'(Done), 0);
    wait_done("F_done2", a2);
    Start = 1'b0;
    chk("F_period", a2 - a1, 62);
    @(negedge Clock);
    chk("F_done2_width", int'(Done), 0);
    repeat (4) @(negedge Clock);
    chk("F_queue", exp_q.size(), 0);
    chk("F_busy", int'(Busy), 0);

    repeat (2) @(negedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/weight_update_sequencer.md
WEIGHT_UPDATE_SEQUENCER -- requirements
Module: weight_update_sequencer

Interface
REQ-001 SHALL have parameters: N_OUT, default 3, output-layer neuron count.
REQ-002 SHALL have parameters: N_HID, default 5, hidden-layer neuron count.
REQ-003 SHALL have parameters: BASE_ADDR, default 50, RAM address of weight (0,0).
REQ-004 SHALL have parameters: FRAC_BITS, default 7, fraction bits of the Q3.7 format.
REQ-005 SHALL have parameters: LR_SHIFT, default 3, learning rate equal to 2^-LR_SHIFT.
REQ-006 SHALL have ports: Clock  in  1  sole clock, rising edge.
REQ-007 SHALL have ports: Rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have ports: Start  in  1  request one full update pass.
REQ-009 SHALL have ports: Delta  in  10 x N_OUT  signed output-layer deltas.
REQ-010 SHALL have ports: OutCal  in  10 x N_HID  unsigned hidden-layer outputs.
REQ-011 SHALL have ports: RamAddr  out  7  weight RAM address.
REQ-012 SHALL have ports: RamWE  out  1  weight RAM write enable.
REQ-013 SHALL have ports: RamWData  out  10  signed updated weight.
REQ-014 SHALL have ports: RamRData  in  10  signed RAM read data, valid one cycle after address.
REQ-015 SHALL have ports: Busy  out  1  pass in progress.
REQ-016 SHALL have ports: Done  out  1  one-cycle pass-complete pulse.

Function
REQ-017 SHALL use FSM states IDLE, READ, WAIT, CALC, WRITE, DONE.
REQ-018 SHALL, in IDLE with Start=1 at an edge, capture Delta and OutCal into internal registers, clear indices n=0, h=0, and go to READ.
REQ-019 SHALL ignore Start in every state other than IDLE; captured operands SHALL stay constant for the whole pass.
REQ-020 SHALL drive RamAddr = BASE_ADDR + n*N_HID + h in READ, WAIT, CALC and WRITE.
REQ-021 SHALL sequence READ->WAIT->CALC->WRITE, taking 4 cycles per weight.
REQ-022 SHALL register old weight w from RamRData in WAIT.
REQ-023 SHALL, in CALC, compute p = Delta[n]*OutCal[h] as a 20-bit signed product, adj = p >>> (FRAC_BITS+LR_SHIFT), and new = w + adj, then saturate new to [-512, 511].
REQ-024 SHALL assert RamWE=1 with RamWData=new only in WRITE; RamWE SHALL be 0 in all other states.
REQ-025 SHALL, after WRITE, increment h; when h wraps from N_HID-1 to 0, it SHALL increment n; after (N_OUT-1, N_HID-1) it SHALL go to DONE, otherwise to READ.
REQ-026 SHALL process weights in neuron-major order (n outer loop, h inner loop).
REQ-027 SHALL assert Done for exactly one cycle in DONE, then return to IDLE.
REQ-028 SHALL hold Busy=1 in every state except IDLE.
REQ-029 SHALL complete a default-parameter pass in 60 edges from the Start edge to entry into DONE, with Done high in the cycle that follows.
REQ-030 SHALL hold RamAddr at its last value in IDLE and DONE.
REQ-031 SHALL accept Start on the edge immediately after DONE, because IDLE is entered for only one cycle.

Reset
REQ-032 SHALL, on Rst=1, asynchronously force state=IDLE, n=h=0, RamWE=0, RamAddr=0, RamWData=0, Busy=0, Done=0, and clear captured operands.
REQ-033 SHALL abort a pass on reset mid-operation with no further writes; weights already written SHALL remain written.
REQ-034 SHALL NOT accept Start while Rst=1.

Configuration
REQ-035 SHALL, with WUS_SAT_COUNT_EN defined, add output SatCount (8 bits), counting CALC cycles in which saturation clipped new; SatCount SHALL stick at 255 and clear on Rst and on an accepted Start.
REQ-036 SHALL, without WUS_SAT_COUNT_EN, omit the SatCount port and its logic entirely, with all other behaviour identical.

Structure
REQ-037 SHALL import package nn_pkg, providing the state enum, the 10-bit weight typedef, WEIGHT_MIN/WEIGHT_MAX, and the Q-format constants.
REQ-038 SHALL contain one sub-module, weight_adjust, a combinational block for multiply, shift, add and saturate, instanced once.

Verification
REQ-039 SHALL cover: Rst, then Start with Delta={64,0,0}, OutCal={128,0,0,0,0}, RAM[50]=100 -> RAM[50]=108 (64*128>>>10 = 8), RAM[51..64] unchanged in value, and Done 60 edges after Start.
REQ-040 SHALL cover: RAM[55]=500, Delta[1]=511, OutCal[0]=1023 -> adj=510, RamWData=511 (saturated), SatCount=1 when the macro is defined.
REQ-041 SHALL cover: RAM[60]=-500, Delta[2]=-512, OutCal[0]=1023 -> RamWData=-512.
REQ-042 SHALL cover: Start pulsed again at edge 20 of a pass -> ignored; exactly 15 writes at addresses 50..64 in order; a single Done.
REQ-043 SHALL cover: Rst asserted mid-cycle during WRITE of address 57 -> RamWE falls immediately, Busy=0, and no write occurs to 58.
REQ-044 SHALL cover: Start held high continuously -> back-to-back passes, each 62 cycles apart with a single-cycle Done.
